// File: rtl/ifu_mem_resp.sv
// Instruction-memory responder: single outstanding PC fetch, programmable wait, preload port.
// Define IFU_MEM_ERR_EN to flag misaligned/out-of-range fetches with rsp_err and a NOP word.
module ifu_mem_resp #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              flush,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  ld_idx;
    logic              rd_bad;
    logic              ld_bad;

    assign req_ready = (state_q == S_IDLE) & ~flush & ~rst;
    assign accept    = req_valid & req_ready;

    // With LATENCY==1 the read happens on the accept edge, so use the live address.
    assign rd_addr = (state_q == S_IDLE) ? req_addr : addr_q;
    assign rd_idx  = rd_addr[IDX_W+1:2];
    assign ld_idx  = ld_addr[IDX_W+1:2];

`ifdef IFU_MEM_ERR_EN
    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];
    assign rd_bad = (rd_addr[1:0] != 2'b00) |
                    (|rd_addr[ADDR_W-1:IDX_W+2]);
    assign ld_bad = |ld_addr[ADDR_W-1:IDX_W+2];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[1:0],
                                rd_addr[ADDR_W-1:IDX_W+2],
                                ld_addr[1:0],
                                ld_addr[ADDR_W-1:IDX_W+2]};
    assign rd_bad = 1'b0;
    assign ld_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    cnt_d  = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        rd_en   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RESP;
                        rd_en   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Array read sees pre-edge contents, giving read-before-write.
        if (rd_en) begin
            if (rd_bad) begin
                data_d = NOP_WORD;
                err_d  = 1'b1;
            end else begin
                data_d = mem_q[rd_idx];
                err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_we && !ld_bad) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule
